mem_loader_ctrl: RTL and testbench

MEM_LOADER_CTRL -- requirements
Module: mem_loader_ctrl

---
 rtl/mem_loader_ctrl.sv | 116 +++++++++++
 tb/tb_mem_loader_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_loader_ctrl.sv
// Boot loader front-end: streams loader bytes into on-chip RAM, holds the CPU in reset
// for REL_CYC cycles after the load, then gives the CPU single-cycle read/write access.
module mem_loader_ctrl #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned REL_CYC = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_read,
  input  logic [ADDR_W-1:0] M_address,
  input  logic [7:0]        M_data_out,
  output logic [7:0]        M_data_in,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_reset_n,
  output logic              load_done,
  output logic [ADDR_W:0]   ld_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned RC_W  = 4;
  localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};
  localparam logic [RC_W-1:0]   REL_LAST = RC_W'(REL_CYC - 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ld_ptr;
  logic [ADDR_W-1:0] w_ld_ptr_nxt;
  logic [CNT_W-1:0]  r_ld_count;
  logic [CNT_W-1:0]  w_ld_count_nxt;
  logic [RC_W-1:0]   r_rel_cnt;
  logic [RC_W-1:0]   w_rel_cnt_nxt;
  logic              w_xfer;
  logic              w_run;

  logic [7:0] r_mem [DEPTH];

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_LOAD;
      r_ld_ptr   <= '0;
      r_ld_count <= '0;
      r_rel_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ld_ptr   <= w_ld_ptr_nxt;
      r_ld_count <= w_ld_count_nxt;
      r_rel_cnt  <= w_rel_cnt_nxt;
    end
  end

  // Next-state logic; the last address forces the exit so the pointer never takes a second pass
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_ptr_nxt   = r_ld_ptr;
    w_ld_count_nxt = r_ld_count;
    w_rel_cnt_nxt  = r_rel_cnt;
    w_xfer         = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (ld_valid) begin
          w_xfer         = 1'b1;
          w_ld_ptr_nxt   = r_ld_ptr + ADDR_W'(1);
          w_ld_count_nxt = r_ld_count + CNT_W'(1);
          if (ld_last || (r_ld_ptr == PTR_MAX)) begin
            w_state_nxt   = S_RELEASE;
            w_rel_cnt_nxt = '0;
          end
        end
      end
      S_RELEASE: begin
        if (r_rel_cnt == REL_LAST) begin
          w_state_nxt = S_RUN;
        end else begin
          w_rel_cnt_nxt = r_rel_cnt + RC_W'(1);
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  assign w_run       = (r_state == S_RUN);
  assign ld_ready    = (r_state == S_LOAD);
  assign cpu_reset_n = w_run;
  assign load_done   = w_run;
  assign ld_count    = r_ld_count;

  // Byte array; not reset, and reset drops any write in the same cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_xfer) begin
        r_mem[r_ld_ptr] <= ld_data;
      end else if (w_run && write_read) begin
        r_mem[M_address] <= M_data_out;
      end
    end
  end

  assign M_data_in = w_run ? r_mem[M_address] : 8'h00;

endmodule

// File: tb/tb_mem_loader_ctrl.sv
// Directed self-checking bench for mem_loader_ctrl with hand-computed expectations.
module tb_mem_loader_ctrl;

  localparam int unsigned ADDR_W = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic              write_read;
  logic [ADDR_W-1:0] M_address;
  logic [7:0]        M_data_out;
  logic [7:0]        M_data_in;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              cpu_reset_n;
  logic              load_done;
  logic [ADDR_W:0]   ld_count;

  int checks   = 0;
  int failures = 0;

  mem_loader_ctrl #(.ADDR_W(ADDR_W), .REL_CYC(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .write_read (write_read),
    .M_address  (M_address),
    .M_data_out (M_data_out),
    .M_data_in  (M_data_in),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .cpu_reset_n(cpu_reset_n),
    .load_done  (load_done),
    .ld_count   (ld_count)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; write_read = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    M_address = '0;
    #1;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ld_ready); end
    checks++; if (cpu_reset_n !== 1'b0) begin failures++; $display("FAIL rst_cpu_reset_n got=%b exp=0", cpu_reset_n); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL rst_load_done got=%b exp=0", load_done); end
    checks++; if (ld_count !== 13'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", ld_count); end
    checks++; if (M_data_in !== 8'h00) begin failures++; $display("FAIL rst_data_in got=%h exp=00", M_data_in); end
  endtask

  task automatic test_basic_load;
    logic [7:0] bytes [3];
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = bytes[i]; ld_last = (i == 2);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    checks++; if (ld_count !== 13'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", ld_count); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL basic_rel_ready got=%b exp=0", ld_ready); end
    checks++; if (cpu_reset_n !== 1'b0) begin failures++; $display("FAIL basic_rel0 cpu_reset_n got=%b exp=0", cpu_reset_n); end
    checks++; if (M_data_in !== 8'h00) begin failures++; $display("FAIL basic_rel_data_in got=%h exp=00", M_data_in); end
    tick();
    checks++; if (cpu_reset_n !== 1'b0) begin failures++; $display("FAIL basic_rel1 cpu_reset_n got=%b exp=0", cpu_reset_n); end
    tick();
    checks++; if (cpu_reset_n !== 1'b1) begin failures++; $display("FAIL basic_run cpu_reset_n got=%b exp=1", cpu_reset_n); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL basic_run load_done got=%b exp=1", load_done); end
    for (int i = 0; i < 3; i++) begin
      M_address = ADDR_W'(i);
      #1;
      checks++; if (M_data_in !== bytes[i]) begin failures++; $display("FAIL basic_read addr=%0d got=%h exp=%h", i, M_data_in, bytes[i]); end
    end
  endtask

  task automatic test_ram_rw;
    M_address = 12'h0A5; M_data_out = 8'h77; write_read = 1'b1;
    tick();
    M_data_out = 8'h5C;
    #1;
    checks++; if (M_data_in !== 8'h77) begin failures++; $display("FAIL rw_same_cycle got=%h exp=77", M_data_in); end
    tick();
    write_read = 1'b0;
    #1;
    checks++; if (M_data_in !== 8'h5C) begin failures++; $display("FAIL rw_after_write got=%h exp=5C", M_data_in); end
  endtask

  task automatic test_run_ignores_loader;
    ld_valid = 1'b1; ld_data = 8'hFF; ld_last = 1'b1;
    repeat (3) tick();
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL run_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (ld_count !== 13'd3) begin failures++; $display("FAIL run_count got=%0d exp=3", ld_count); end
    ld_valid = 1'b0; ld_last = 1'b0;
    M_address = 12'h003;
    #1;
    checks++; if (M_data_in !== 8'h00 && M_data_in === 8'hFF) begin failures++; $display("FAIL run_addr3 got=%h exp=not FF", M_data_in); end
    M_address = 12'h000;
    #1;
    checks++; if (M_data_in !== 8'h12) begin failures++; $display("FAIL run_addr0 got=%h exp=12", M_data_in); end
  endtask

  task automatic test_reset_mid_load;
    do_reset();
    ld_valid = 1'b1; ld_data = 8'hAA; tick();
    ld_data = 8'hBB; tick();
    reset = 1'b1; ld_data = 8'hCC; tick();
    reset = 1'b0; ld_valid = 1'b0;
    checks++; if (ld_count !== 13'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", ld_count); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ld_ready); end
    checks++; if (cpu_reset_n !== 1'b0) begin failures++; $display("FAIL midrst_cpu_reset_n got=%b exp=0", cpu_reset_n); end
    write_read = 1'b1; M_address = 12'h002; M_data_out = 8'h99; tick();
    write_read = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hDD; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    checks++; if (ld_count !== 13'd1) begin failures++; $display("FAIL midrst_count2 got=%0d exp=1", ld_count); end
    repeat (2) tick();
    M_address = 12'h000; #1;
    checks++; if (M_data_in !== 8'hDD) begin failures++; $display("FAIL midrst_addr0 got=%h exp=DD", M_data_in); end
    M_address = 12'h001; #1;
    checks++; if (M_data_in !== 8'hBB) begin failures++; $display("FAIL midrst_addr1 got=%h exp=BB", M_data_in); end
    M_address = 12'h002; #1;
    checks++; if (M_data_in !== 8'hF0) begin failures++; $display("FAIL midrst_addr2 got=%h exp=F0", M_data_in); end
  endtask

  task automatic test_valid_gaps;
    logic       vld [4];
    logic [3:0] exp_cnt [4];
    logic       exp_rdy [4];
    vld[0] = 1; vld[1] = 0; vld[2] = 0; vld[3] = 1;
    exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 1; exp_cnt[3] = 2;
    exp_rdy[0] = 1; exp_rdy[1] = 1; exp_rdy[2] = 1; exp_rdy[3] = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ld_valid = vld[i]; ld_data = 8'(8'h40 + i); ld_last = (i == 3);
      tick();
      checks++; if (ld_count !== 13'(exp_cnt[i])) begin failures++; $display("FAIL gaps_count cyc=%0d got=%0d exp=%0d", i, ld_count, exp_cnt[i]); end
      checks++; if (ld_ready !== exp_rdy[i]) begin failures++; $display("FAIL gaps_ready cyc=%0d got=%b exp=%b", i, ld_ready, exp_rdy[i]); end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    repeat (2) tick();
    M_address = 12'h001; #1;
    checks++; if (M_data_in !== 8'h43) begin failures++; $display("FAIL gaps_addr1 got=%h exp=43", M_data_in); end
  endtask

  task automatic test_full_load;
    do_reset();
    ld_last = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i);
      if (i == 4095) begin
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL full_ready_last got=%b exp=1", ld_ready); end
      end
      tick();
    end
    checks++; if (ld_count !== 13'd4096) begin failures++; $display("FAIL full_count got=%0d exp=4096", ld_count); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL full_ready_4097 got=%b exp=0", ld_ready); end
    ld_data = 8'hEE; tick();
    checks++; if (ld_count !== 13'd4096) begin failures++; $display("FAIL full_count_4097 got=%0d exp=4096", ld_count); end
    ld_valid = 1'b0;
    tick();
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL full_load_done got=%b exp=1", load_done); end
    M_address = 12'hFFF; #1;
    checks++; if (M_data_in !== 8'hFF) begin failures++; $display("FAIL full_addr_fff got=%h exp=FF", M_data_in); end
    M_address = 12'h000; #1;
    checks++; if (M_data_in !== 8'h00) begin failures++; $display("FAIL full_addr_000 got=%h exp=00", M_data_in); end
    M_address = 12'h0A5; #1;
    checks++; if (M_data_in !== 8'hA5) begin failures++; $display("FAIL full_addr_0a5 got=%h exp=A5", M_data_in); end
  endtask

  initial begin
    reset = 1'b1; write_read = 1'b0; M_address = '0; M_data_out = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    test_reset();
    test_basic_load();
    test_ram_rw();
    test_run_ignores_loader();
    test_reset_mid_load();
    test_valid_gaps();
    test_full_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
